// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational 8-bit ALU: arbitrates, registers
// operands onto the ALU, captures the result and returns it tagged with the requester id.
module alu_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_req0_valid,
  output logic       out_req0_ready,
  input  logic [7:0] in_req0_a,
  input  logic [7:0] in_req0_b,
  input  logic [2:0] in_req0_op,
  input  logic       in_req1_valid,
  output logic       out_req1_ready,
  input  logic [7:0] in_req1_a,
  input  logic [7:0] in_req1_b,
  input  logic [2:0] in_req1_op,
  output logic [7:0] out_alu_a,
  output logic [7:0] out_alu_b,
  output logic [2:0] out_alu_op,
  input  logic [8:0] in_alu_result,
  output logic       out_rsp_valid,
  output logic       out_rsp_id,
  output logic [8:0] out_rsp_result,
  input  logic       in_rsp_ready,
  output logic [1:0] out_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   prio;
  logic   grant1;
  logic   accept;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Ready is a function of valid (and state/prio); requesters assert valid without waiting
  // for ready, and the response side holds valid/id/result stable until rsp_ready is seen.
  assign grant1         = in_req1_valid & (~in_req0_valid | prio);
  assign out_req0_ready = (state == IDLE) & in_req0_valid & ~grant1;
  assign out_req1_ready = (state == IDLE) & grant1;
  assign accept         = out_req0_ready | out_req1_ready;
  assign out_rsp_valid  = (state == RESP);
  assign out_dbg_state  = state;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (in_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      prio           <= 1'b0;
      out_alu_a      <= 8'h00;
      out_alu_b      <= 8'h00;
      out_alu_op     <= 3'b000;
      out_rsp_id     <= 1'b0;
      out_rsp_result <= 9'h000;
    end else begin
      if (accept) begin
        out_alu_a  <= grant1 ? in_req1_a  : in_req0_a;
        out_alu_b  <= grant1 ? in_req1_b  : in_req0_b;
        out_alu_op <= grant1 ? in_req1_op : in_req0_op;
        out_rsp_id <= grant1;
        // Fixed-priority mode never moves the pointer off requester 0.
        if (RR) prio <= ~grant1;
      end
      if (state == EXEC) out_rsp_result <= in_alu_result;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority instance
// share the same requester stimulus, each driving its own behavioural ALU.
module tb_alu_arbiter;

  logic       in_clk = 1'b0;
  logic       in_rst_n;
  logic       in_req0_valid, in_req1_valid;
  logic [7:0] in_req0_a, in_req0_b, in_req1_a, in_req1_b;
  logic [2:0] in_req0_op, in_req1_op;
  logic       in_rsp_ready;

  logic       req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [8:0] alu_result, rsp_result;
  logic [1:0] dbg_state;

  logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
  logic [7:0] fp_alu_a, fp_alu_b;
  logic [2:0] fp_alu_op;
  logic [8:0] fp_alu_result, fp_rsp_result;
  logic [1:0] fp_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  always #5 in_clk = ~in_clk;

  // Behavioural ALU: op 0 add, op 1 subtract, anything else xor.
  function automatic logic [8:0] alu_f(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign alu_result    = alu_f(alu_a, alu_b, alu_op);
  assign fp_alu_result = alu_f(fp_alu_a, fp_alu_b, fp_alu_op);

  alu_arbiter #(.RR(1'b1)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_req0_valid(in_req0_valid), .out_req0_ready(req0_ready),
    .in_req0_a(in_req0_a), .in_req0_b(in_req0_b), .in_req0_op(in_req0_op),
    .in_req1_valid(in_req1_valid), .out_req1_ready(req1_ready),
    .in_req1_a(in_req1_a), .in_req1_b(in_req1_b), .in_req1_op(in_req1_op),
    .out_alu_a(alu_a), .out_alu_b(alu_b), .out_alu_op(alu_op),
    .in_alu_result(alu_result),
    .out_rsp_valid(rsp_valid), .out_rsp_id(rsp_id), .out_rsp_result(rsp_result),
    .in_rsp_ready(in_rsp_ready), .out_dbg_state(dbg_state)
  );

  alu_arbiter #(.RR(1'b0)) dut_fp (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_req0_valid(in_req0_valid), .out_req0_ready(fp_req0_ready),
    .in_req0_a(in_req0_a), .in_req0_b(in_req0_b), .in_req0_op(in_req0_op),
    .in_req1_valid(in_req1_valid), .out_req1_ready(fp_req1_ready),
    .in_req1_a(in_req1_a), .in_req1_b(in_req1_b), .in_req1_op(in_req1_op),
    .out_alu_a(fp_alu_a), .out_alu_b(fp_alu_b), .out_alu_op(fp_alu_op),
    .in_alu_result(fp_alu_result),
    .out_rsp_valid(fp_rsp_valid), .out_rsp_id(fp_rsp_id), .out_rsp_result(fp_rsp_result),
    .in_rsp_ready(in_rsp_ready), .out_dbg_state(fp_dbg_state)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    in_rst_n = 1'b0;
    in_req0_valid = 1'b0; in_req1_valid = 1'b0;
    in_req0_a = 8'h00; in_req0_b = 8'h00; in_req0_op = 3'd0;
    in_req1_a = 8'h00; in_req1_b = 8'h00; in_req1_op = 3'd0;
    in_rsp_ready = 1'b1;

    // Reset values
    tick(); tick();
    chk("rst_state", 16'(dbg_state), 16'(S_IDLE));
    chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("rst_alu_a", 16'(alu_a), 16'h0);
    chk("rst_alu_op", 16'(alu_op), 16'h0);
    chk("rst_result", 16'(rsp_result), 16'h0);
    chk("rst_ready0", 16'(req0_ready), 16'h0);
    in_rst_n = 1'b1;
    tick();

    // Single add from requester 0
    in_req0_valid = 1'b1; in_req0_a = 8'h03; in_req0_b = 8'h05; in_req0_op = 3'd0;
    #1;
    chk("add_ready0", 16'(req0_ready), 16'h1);
    chk("add_ready1", 16'(req1_ready), 16'h0);
    tick();
    in_req0_valid = 1'b0;
    #1;
    chk("add_exec_state", 16'(dbg_state), 16'(S_EXEC));
    chk("add_exec_valid", 16'(rsp_valid), 16'h0);
    chk("add_alu_a", 16'(alu_a), 16'h03);
    chk("add_alu_b", 16'(alu_b), 16'h05);
    tick();
    chk("add_rsp_valid", 16'(rsp_valid), 16'h1);
    chk("add_rsp_id", 16'(rsp_id), 16'h0);
    chk("add_rsp_result", 16'(rsp_result), 16'h008);
    tick();
    chk("add_back_idle", 16'(dbg_state), 16'(S_IDLE));
    chk("add_valid_drop", 16'(rsp_valid), 16'h0);

    // Carry from requester 1
    in_req1_valid = 1'b1; in_req1_a = 8'hFF; in_req1_b = 8'h01; in_req1_op = 3'd0;
    #1;
    chk("carry_ready1", 16'(req1_ready), 16'h1);
    tick();
    in_req1_valid = 1'b0;
    #1;
    chk("carry_alu_a", 16'(alu_a), 16'hFF);
    chk("carry_alu_b", 16'(alu_b), 16'h01);
    tick();
    chk("carry_alu_a_hold", 16'(alu_a), 16'hFF);
    chk("carry_rsp_id", 16'(rsp_id), 16'h1);
    chk("carry_rsp_result", 16'(rsp_result), 16'h100);
    tick();

    // Contention: RR instance alternates 0,1,0,1; fixed-priority instance always grants 0
    in_req0_valid = 1'b1; in_req0_a = 8'h10; in_req0_b = 8'h20; in_req0_op = 3'd0;
    in_req1_valid = 1'b1; in_req1_a = 8'h40; in_req1_b = 8'h05; in_req1_op = 3'd1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_idle", 16'(dbg_state), 16'(S_IDLE));
      chk("rr_ready0", 16'(req0_ready), (i % 2 == 0) ? 16'h1 : 16'h0);
      chk("rr_ready1", 16'(req1_ready), (i % 2 == 1) ? 16'h1 : 16'h0);
      chk("fp_ready0", 16'(fp_req0_ready), 16'h1);
      chk("fp_ready1", 16'(fp_req1_ready), 16'h0);
      tick();
      chk("rr_alu_op", 16'(alu_op), (i % 2 == 1) ? 16'h1 : 16'h0);
      chk("rr_exec_valid", 16'(rsp_valid), 16'h0);
      chk("fp_wait_ready1", 16'(fp_req1_ready), 16'h0);
      tick();
      chk("rr_rsp_valid", 16'(rsp_valid), 16'h1);
      chk("rr_rsp_id", 16'(rsp_id), (i % 2 == 1) ? 16'h1 : 16'h0);
      chk("rr_rsp_result", 16'(rsp_result), (i % 2 == 1) ? 16'h03B : 16'h030);
      chk("fp_rsp_id", 16'(fp_rsp_id), 16'h0);
      chk("fp_rsp_result", 16'(fp_rsp_result), 16'h030);
      chk("fp_resp_ready1", 16'(fp_req1_ready), 16'h0);
      tick();
    end

    // Backpressure: RR instance prio is 0 here, requester 0 alone wins
    in_req1_valid = 1'b0;
    #1;
    chk("bp_ready0", 16'(req0_ready), 16'h1);
    tick();
    in_rsp_ready = 1'b0;
    tick();
    in_req1_valid = 1'b1;
    in_req0_a = 8'h77;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 16'(rsp_valid), 16'h1);
      chk("bp_id", 16'(rsp_id), 16'h0);
      chk("bp_result", 16'(rsp_result), 16'h030);
      chk("bp_ready0_low", 16'(req0_ready), 16'h0);
      chk("bp_ready1_low", 16'(req1_ready), 16'h0);
      tick();
    end
    in_req0_a = 8'h10;
    in_rsp_ready = 1'b1;
    #1;
    chk("bp_still_resp", 16'(dbg_state), 16'(S_RESP));
    tick();
    chk("bp_reidle", 16'(dbg_state), 16'(S_IDLE));
    chk("bp_pending_ready1", 16'(req1_ready), 16'h1);
    chk("bp_pending_ready0", 16'(req0_ready), 16'h0);
    tick();
    chk("bp_pending_alu_a", 16'(alu_a), 16'h40);
    chk("bp_pending_alu_op", 16'(alu_op), 16'h1);
    tick();
    chk("bp_pending_id", 16'(rsp_id), 16'h1);
    chk("bp_pending_result", 16'(rsp_result), 16'h03B);
    tick();

    // Reset during EXEC; prio is 1 after this accept, reset must return it to 0
    in_req0_a = 8'h21; in_req0_b = 8'h12;
    #1;
    chk("rstop_ready0", 16'(req0_ready), 16'h1);
    tick();
    chk("rstop_exec", 16'(dbg_state), 16'(S_EXEC));
    #2;
    in_rst_n = 1'b0;
    #1;
    chk("rstop_valid", 16'(rsp_valid), 16'h0);
    chk("rstop_alu_a", 16'(alu_a), 16'h0);
    chk("rstop_alu_b", 16'(alu_b), 16'h0);
    chk("rstop_alu_op", 16'(alu_op), 16'h0);
    chk("rstop_result", 16'(rsp_result), 16'h0);
    chk("rstop_state", 16'(dbg_state), 16'(S_IDLE));
    tick();
    in_rst_n = 1'b1;
    #1;
    chk("rel_no_stale", 16'(rsp_valid), 16'h0);
    chk("rel_ready0", 16'(req0_ready), 16'h1);
    chk("rel_ready1", 16'(req1_ready), 16'h0);
    tick();
    chk("rel_alu_a", 16'(alu_a), 16'h21);
    chk("rel_no_stale_exec", 16'(rsp_valid), 16'h0);
    tick();
    chk("rel_rsp_id", 16'(rsp_id), 16'h0);
    chk("rel_rsp_result", 16'(rsp_result), 16'h033);
    tick();

    in_req0_valid = 1'b0; in_req1_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 8-bit `alu` between two requesters using valid/ready handshakes. It arbitrates between the requesters, registers the winning operands and opcode onto the ALU inputs, and captures the 9-bit ALU result one cycle later. The result is then returned on a single response channel, tagged with the requester ID. The block sits between the requester logic and the `alu` instance and is the only driver of the ALU's inputs.

## Interface
- `RR`, default 1: arbitration mode. 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.

Ports:
- `in_clk` input 1: clock; every register updates on the rising edge.
- `in_rst_n` input 1: reset, asynchronous and active-low.
- `in_req0_valid` input 1: requester 0 has an operation pending.
- `out_req0_ready` output 1: requester 0 operation is accepted this cycle.
- `in_req0_a`, `in_req0_b` input 8 each: requester 0 operands.
- `in_req0_op` input 3: requester 0 opcode.
- `in_req1_valid`, `out_req1_ready`, `in_req1_a`, `in_req1_b`, `in_req1_op`: the same signals for requester 1.
- `out_alu_a`, `out_alu_b` output 8 each: registered operands to the ALU.
- `out_alu_op` output 3: registered opcode to the ALU.
- `in_alu_result` input 9: ALU result, combinational from `out_alu_*`.
- `out_rsp_valid` output 1: a response is available.
- `out_rsp_id` output 1: requester that owns the response.
- `out_rsp_result` output 9: registered ALU result.
- `in_rsp_ready` input 1: the consumer takes the response.

## Operation
- **States:**
  - IDLE accepts requests.
  - EXEC lets the ALU evaluate.
  - RESP holds the response until the consumer takes it.
- **Priority pointer `prio` (1 bit):**
  - Reset value 0, meaning requester 0 is preferred.
  - With `RR=0`, `prio` is held at 0.
- **Grant in IDLE (combinational):**
  - If only one valid is high, grant that requester.
  - If both are high, grant requester `prio`.
  - `out_reqN_ready` = (state==IDLE) & granted N. At most one ready is high in any cycle.
  - Ready depends on valid. A requester must not wait for ready before asserting valid.
- **Handshake on a rising edge in IDLE with grant N:**
  - `out_alu_a/b/op` load from requester N.
  - The ID register loads N.
  - With `RR=1`, `prio` loads ~N.
  - State goes to EXEC.
- **IDLE with no valid:** nothing changes. `out_alu_*` hold their last values.
- **EXEC:** on the next edge, `out_rsp_result` loads `in_alu_result` unmodified, all 9 bits, and state goes to RESP. This state cannot stall.
- **RESP:**
  - `out_rsp_valid` = 1.
  - `out_rsp_id` and `out_rsp_result` hold stable until the edge where `in_rsp_ready`=1; on that edge state goes to IDLE.
  - Both ready outputs stay low until then.
- **Response-only signals:** `out_rsp_valid` is high only in RESP. `out_rsp_id` and `out_rsp_result` are meaningful only when `out_rsp_valid` is high, but are registered and hold their values otherwise.
- **Unlisted inputs:** valid or operand changes outside an accepting edge are ignored, because operands are captured only on the handshake.
- **Opcode:** carried through to `out_alu_op` without interpretation.

## Timing
- **Reset (async, `in_rst_n`=0):**
  - State = IDLE, `prio` = 0.
  - `out_alu_a`/`out_alu_b` = 8'h00, `out_alu_op` = 3'b000.
  - `out_rsp_result` = 9'h000, `out_rsp_id` = 0, `out_rsp_valid` = 0.
  - `out_req0_ready` and `out_req1_ready` follow the IDLE rules and are never forced high by reset.
  - Reset mid-EXEC or mid-RESP abandons the operation with no response. Release puts the block back in IDLE.
- **Latency:**
  - Accept edge E0.
  - Result captured at E0+1.
  - `out_rsp_valid` high from the cycle after E0+1.
  - Earliest consume edge is E0+2.
  - Earliest next accept edge is E0+3, so peak throughput is 1 operation per 3 cycles.
- **Simultaneous events:**
  - A request arriving while the block is in EXEC or RESP waits; it is not lost as long as the requester holds valid.
  - A held request is arbitrated on the first IDLE cycle using the updated `prio`.
  - Response consume and a new accept never happen on the same edge.
- **Backpressure:** `in_rsp_ready` low holds RESP indefinitely, and all outputs stay stable during the hold.

## Test plan
- **Single add:** reset, then req0 a=8'h03 b=8'h05 op=3'b000 while the ALU is modelled as an adder.
  - Required: `out_req0_ready` high in the accept cycle.
  - Required: rsp_valid 2 cycles later with id=0, result=9'h008.
- **Carry:** req1 a=8'hFF b=8'h01.
  - Required: response id=1, result=9'h100.
  - Required: `out_alu_a`/`out_alu_b` equal 8'hFF/8'h01 from the accept edge onward.
- **Contention with `RR=1`:** both valid continuously with rsp_ready=1.
  - Required: grants go 0,1,0,1.
  - Required: responses carry matching ids and results, one response every 3 cycles.
- **Fixed priority with `RR=0`:** both valid held for 3 operations.
  - Required: all three grants go to requester 0, and requester 1 waits with ready low.
- **Backpressure:** hold rsp_ready=0 for 5 cycles in RESP.
  - Required: valid, id and result stable throughout, and both req ready outputs low.
  - Required: on rsp_ready=1, IDLE is re-entered one cycle later and the pending request is accepted.
- **Reset mid-operation:** assert `in_rst_n`=0 asynchronously while in EXEC.
  - Required: immediately, rsp_valid=0, alu outputs=0 and result=0.
  - Required: after release, no stale response appears, and the next request from requester 0 wins when both are valid.
